// File: rtl/bcd_seq_player.sv
// BCD sequence player: fetches records of DIGITS value digits and DIGITS
// duration digits from nibble memory, plays each value for its duration,
// and prefetches the following record into a shadow register during playback.
module bcd_seq_player #(
  parameter int DIGITS = 2,
  parameter int ADDR_W = 8,
  parameter int OUT_W  = 7
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              loop,
  input  logic [ADDR_W-1:0] base_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic              mem_rdy,
  input  logic [3:0]        mem_data,
  output logic [OUT_W-1:0]  out,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              late
);

  localparam int NDIG  = 2 * DIGITS;
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FIRST, S_PLAY} state_t;
  typedef enum logic       {F_RD, F_FULL}            fetch_t;

  state_t             r_state;
  fetch_t             r_fst;
  logic [ADDR_W-1:0]  r_addr;
  logic [ADDR_W-1:0]  r_base;
  logic               r_loop;
  logic               r_rd;
  logic [OUT_W-1:0]   r_out;
  logic [OUT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic               r_err;
  logic               r_late;
  logic [IDX_W-1:0]   r_dig;
  logic [OUT_W-1:0]   r_vacc;
  logic [OUT_W-1:0]   r_dacc;
  logic [OUT_W-1:0]   r_sh_val;
  logic [OUT_W-1:0]   r_sh_dur;
  logic               r_sh_term;

  logic               w_acc;
  logic               w_bad;
  logic               w_last;
  logic               w_in_dur;
  logic [OUT_W-1:0]   w_digit;
  logic [OUT_W-1:0]   w_vnext;
  logic [OUT_W-1:0]   w_dnext;
  logic               w_rec_done;
  logic               w_term;
  logic               w_expire;

  // Digit acceptance, Horner accumulation and record-boundary decode
  always_comb begin
    w_acc      = r_rd & mem_rdy;
    w_bad      = (mem_data > 4'd9);
    w_last     = (r_dig == IDX_W'(NDIG - 1));
    w_in_dur   = (r_dig >= IDX_W'(DIGITS));
    w_digit    = OUT_W'(mem_data);
    w_vnext    = r_vacc * OUT_W'(10) + w_digit;
    w_dnext    = r_dacc * OUT_W'(10) + w_digit;
    w_rec_done = w_acc & ~w_bad & w_last;
    w_term     = (w_dnext == '0);
    w_expire   = (r_cnt == OUT_W'(1));
  end

  // Control FSM, fetch engine, shadow record and playback counter
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_fst     <= F_RD;
      r_addr    <= '0;
      r_base    <= '0;
      r_loop    <= 1'b0;
      r_rd      <= 1'b0;
      r_out     <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_late    <= 1'b0;
      r_dig     <= '0;
      r_vacc    <= '0;
      r_dacc    <= '0;
      r_sh_val  <= '0;
      r_sh_dur  <= '0;
      r_sh_term <= 1'b0;
    end else begin
      // Common digit step; record-level decisions below may override r_addr
      if (w_acc && !w_bad) begin
        r_addr <= r_addr + ADDR_W'(1);
        if (w_last) begin
          r_dig  <= '0;
          r_vacc <= '0;
          r_dacc <= '0;
        end else begin
          r_dig <= r_dig + IDX_W'(1);
          if (w_in_dur) r_dacc <= w_dnext;
          else          r_vacc <= w_vnext;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_FIRST;
            r_fst   <= F_RD;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_late  <= 1'b0;
            r_loop  <= loop;
            r_base  <= base_addr;
            r_addr  <= base_addr;
            r_rd    <= 1'b1;
            r_dig   <= '0;
            r_vacc  <= '0;
            r_dacc  <= '0;
          end
        end

        S_FIRST: begin
          if (w_acc && w_bad) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_rd    <= 1'b0;
            r_err   <= 1'b1;
          end else if (w_rec_done) begin
            if (!w_term) begin
              // Playback starts; the fetch engine keeps reading the next record
              r_out   <= r_vacc;
              r_cnt   <= w_dnext;
              r_state <= S_PLAY;
            end else if (r_loop) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_rd    <= 1'b0;
              r_err   <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_rd    <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end

        S_PLAY: begin
          if (!w_expire) r_cnt <= r_cnt - OUT_W'(1);

          if (w_acc && w_bad) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_rd    <= 1'b0;
            r_fst   <= F_RD;
            r_err   <= 1'b1;
          end else if (w_rec_done) begin
            // A record completing on the expiry edge is handed straight to
            // the output instead of passing through the shadow register.
            if (w_term && r_loop) begin
              r_addr <= r_base;
              if (w_expire) r_late <= 1'b1;
            end else if (w_expire) begin
              if (w_term) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_rd    <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_out <= r_vacc;
                r_cnt <= w_dnext;
              end
            end else begin
              r_sh_val  <= r_vacc;
              r_sh_dur  <= w_dnext;
              r_sh_term <= w_term;
              r_fst     <= F_FULL;
              r_rd      <= 1'b0;
            end
          end else if (w_expire) begin
            if (r_fst == F_FULL) begin
              if (r_sh_term) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_fst   <= F_RD;
              end else begin
                r_out <= r_sh_val;
                r_cnt <= r_sh_dur;
                r_fst <= F_RD;
                r_rd  <= 1'b1;
              end
            end else begin
              // Underrun: hold the current value until the record arrives
              r_late <= 1'b1;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_addr = r_addr;
  assign mem_rd   = r_rd;
  assign out      = r_out;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;
  assign late     = r_late;

endmodule
